// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one byte-addressable data memory between three requesters:
//   port 0 = program loader, port 1 = core data, port 2 = instruction fetch.
// Fixed priority 0 > 1 > 2, no preemption. Each granted transaction runs
// through the memory's fixed read latency, or through its alignment check and
// done/error write handshake. It then returns exactly one registered, one-hot
// acknowledge.
//
// Ports (packed vectors: port n occupies slice n):
//   clk, rst          clock, synchronous active-high reset
//   req[3]            per-port request level
//   req_addr          3 x WORD_SIZE byte addresses
//   req_wdata         3 x WORD_SIZE write data
//   req_wsize[6]      3 x 2-bit write size, 0 = read (port 2 always reads)
//   ack[3]            one-hot, single-cycle acknowledge
//   rsp_rdata         read data, valid while ack != 0
//   rsp_err           error flag, valid while ack != 0
//   mem_address       memory byte address
//   mem_wdata         memory write data (MSB byte goes to d0)
//   mem_write[2]      memory write size strobe
//   mem_rdata         memory read data
//   mem_done          memory write complete
//   mem_error         memory alignment error
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int WORD_SIZE = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               req,
  input  logic [3*WORD_SIZE-1:0]   req_addr,
  input  logic [3*WORD_SIZE-1:0]   req_wdata,
  input  logic [5:0]               req_wsize,
  output logic [2:0]               ack,
  output logic [WORD_SIZE-1:0]     rsp_rdata,
  output logic                     rsp_err,
  output logic [WORD_SIZE-1:0]     mem_address,
  output logic [WORD_SIZE-1:0]     mem_wdata,
  output logic [1:0]               mem_write,
  input  logic [WORD_SIZE-1:0]     mem_rdata,
  input  logic                     mem_done,
  input  logic                     mem_error
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_CAP,
    WR_CHK,
    WR_DRV,
    RESP
  } state_t;

  state_t state_reg, state_next;

  logic [WORD_SIZE-1:0] mem_address_reg;
  logic [WORD_SIZE-1:0] mem_wdata_reg;
  logic [1:0]           mem_write_reg;
  logic [WORD_SIZE-1:0] rsp_rdata_reg;
  logic                 rsp_err_reg;
  logic [2:0]           ack_reg;
  logic [1:0]           wsize_reg;
  logic [1:0]           port_reg;
  logic [7:0]           count_reg;

  // Per-port views of the packed request buses.
  logic [WORD_SIZE-1:0] port_addr  [3];
  logic [WORD_SIZE-1:0] port_wdata [3];
  logic [1:0]           port_wsize [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_port
      assign port_addr[gi]  = req_addr[gi*WORD_SIZE +: WORD_SIZE];
      assign port_wdata[gi] = req_wdata[gi*WORD_SIZE +: WORD_SIZE];
      if (gi == 2) begin : g_fetch
        // Instruction fetch never writes; its size slice is ignored.
        assign port_wsize[gi] = 2'b00;
      end else begin : g_rw
        assign port_wsize[gi] = req_wsize[2*gi +: 2];
      end
    end
  endgenerate

  logic unused_fetch_wsize;
  assign unused_fetch_wsize = ^req_wsize[5:4];

  // Fixed-priority selection: lowest port index wins.
  logic                 grant_any;
  logic [1:0]           sel_idx;
  logic [WORD_SIZE-1:0] sel_addr;
  logic [WORD_SIZE-1:0] sel_wdata;
  logic [1:0]           sel_wsize;

  always_comb begin
    grant_any = |req;
    sel_idx   = 2'd0;
    sel_addr  = port_addr[0];
    sel_wdata = port_wdata[0];
    sel_wsize = port_wsize[0];
    if (req[0]) begin
      sel_idx   = 2'd0;
      sel_addr  = port_addr[0];
      sel_wdata = port_wdata[0];
      sel_wsize = port_wsize[0];
    end else if (req[1]) begin
      sel_idx   = 2'd1;
      sel_addr  = port_addr[1];
      sel_wdata = port_wdata[1];
      sel_wsize = port_wsize[1];
    end else if (req[2]) begin
      sel_idx   = 2'd2;
      sel_addr  = port_addr[2];
      sel_wdata = port_wdata[2];
      sel_wsize = port_wsize[2];
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_any) begin
          state_next = (sel_wsize == 2'b00) ? RD_WAIT : WR_CHK;
        end
      end
      RD_WAIT: state_next = RD_CAP;
      RD_CAP:  state_next = RESP;
      WR_CHK:  state_next = mem_error ? RESP : WR_DRV;
      WR_DRV: begin
        // mem_done wins over the timeout when both happen together.
        if (mem_done || (count_reg == TIMEOUT_CNT)) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      mem_address_reg <= '0;
      mem_wdata_reg   <= '0;
      mem_write_reg   <= 2'b00;
      rsp_rdata_reg   <= '0;
      rsp_err_reg     <= 1'b0;
      ack_reg         <= 3'b000;
      wsize_reg       <= 2'b00;
      port_reg        <= 2'd0;
      count_reg       <= 8'd0;
    end else begin
      state_reg <= state_next;
      ack_reg   <= 3'b000;
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            mem_address_reg <= sel_addr;
            mem_wdata_reg   <= sel_wdata;
            wsize_reg       <= sel_wsize;
            port_reg        <= sel_idx;
          end
        end
        RD_WAIT: begin
          mem_write_reg <= 2'b00;
        end
        RD_CAP: begin
          rsp_rdata_reg <= mem_rdata;
          rsp_err_reg   <= mem_error;
        end
        WR_CHK: begin
          // Alignment is checked before any write strobe is raised, so a
          // misaligned write never reaches the memory.
          if (mem_error) begin
            rsp_err_reg <= 1'b1;
          end else begin
            mem_write_reg <= wsize_reg;
            count_reg     <= 8'd0;
          end
        end
        WR_DRV: begin
          count_reg <= count_reg + 8'd1;
          if (mem_done) begin
            mem_write_reg <= 2'b00;
            rsp_err_reg   <= 1'b0;
          end else if (count_reg == TIMEOUT_CNT) begin
            mem_write_reg <= 2'b00;
            rsp_err_reg   <= 1'b1;
          end
        end
        default: begin
        end
      endcase
      // Acknowledge is registered so it is high exactly during RESP.
      if (state_next == RESP) begin
        ack_reg <= 3'b001 << port_reg;
      end
    end
  end

  assign ack         = ack_reg;
  assign rsp_rdata   = rsp_rdata_reg;
  assign rsp_err     = rsp_err_reg;
  assign mem_address = mem_address_reg;
  assign mem_wdata   = mem_wdata_reg;
  assign mem_write   = mem_write_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed cycle-exact scenarios followed by randomized three-port traffic.
// A behavioural memory (word array, done after a per-region delay, alignment
// error on low address bits) backs the arbiter. Expected responses come from a
// reference memory and are queued per port when a transaction is issued. A
// separate monitor pops and compares them whenever ack is seen.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int W  = 32;
  localparam int TO = 4;
  localparam int N_PER_PORT = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    req;
  logic [3*W-1:0] req_addr;
  logic [3*W-1:0] req_wdata;
  logic [5:0]    req_wsize;
  logic [2:0]    ack;
  logic [W-1:0]  rsp_rdata;
  logic          rsp_err;
  logic [W-1:0]  mem_address;
  logic [W-1:0]  mem_wdata;
  logic [1:0]    mem_write;
  logic [W-1:0]  mem_rdata;
  logic          mem_done;
  logic          mem_error;

  always #5 clk = ~clk;

  mem_arbiter #(.WORD_SIZE(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wsize(req_wsize), .ack(ack),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .mem_done(mem_done), .mem_error(mem_error)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- behavioural memory ----------------
  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  int          pend_delay [4];
  logic        tb_init;
  int          wcount = 0;
  logic        noise = 1'b0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h00500093;
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] wd,
                                        input logic [1:0] sz);
    if (sz == 2'b01) return {old_w[31:8], wd[7:0]};
    if (sz == 2'b11) return {old_w[31:16], wd[15:0]};
    return wd;
  endfunction

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (mem_write != 2'b00 && mem_done) begin
      mem[mem_address[7:2]] <= merge(mem[mem_address[7:2]], mem_wdata, mem_write);
    end
    wcount <= (mem_write != 2'b00) ? wcount + 1 : 0;
  end

  // Random mem_done chatter outside of writes; the arbiter must ignore it.
  always @(negedge clk) noise <= 1'($urandom_range(0, 1));

  assign mem_rdata = mem[mem_address[7:2]];
  assign mem_error = (mem_address[1:0] != 2'b00);
  always_comb begin
    mem_done = noise;
    if (mem_write != 2'b00) mem_done = (wcount == pend_delay[mem_address[7:6]]);
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        rd;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic push_exp(input int p, input exp_t e);
    case (p)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int p, output exp_t e, output bit ok);
    ok = 1'b1;
    e.rdata = '0; e.err = 1'b0; e.rd = 1'b0;
    case (p)
      0: if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
      1: if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
      default: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  // Monitor: one line per acknowledged transaction.
  initial begin
    logic [31:0] last_rd;
    logic [2:0]  prev_ack;
    exp_t        e;
    bit          ok;
    last_rd  = '0;
    prev_ack = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_rd  = '0;
        prev_ack = '0;
      end else begin
        if (ack != 3'b000) begin
          chk("ack_onehot", 32'($countones(ack)), 32'd1);
          chk("ack_back_to_back", {29'd0, prev_ack}, 32'd0);
          for (int p = 0; p < 3; p++) begin
            if (ack[p]) begin
              $display("[TB] t=%0t ack port %0d rdata=%h err=%0b", $time, p, rsp_rdata, rsp_err);
              pop_exp(p, e, ok);
              chk("sb_expected_txn", {31'd0, ok}, 32'd1);
              if (ok) begin
                chk("sb_rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                if (e.rd) begin
                  chk("sb_rsp_rdata", rsp_rdata, e.rdata);
                  last_rd = e.rdata;
                end else begin
                  chk("sb_rdata_hold", rsp_rdata, last_rd);
                end
              end
            end
          end
        end
        prev_ack = ack;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int p, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] wsize, input int delay, input bit track);
    exp_t       e;
    logic [5:0] wi;
    wi   = addr[7:2];
    e.rd = (p == 2) || (wsize == 2'b00);
    e.rdata = '0;
    if (e.rd) begin
      e.rdata = ref_mem[wi];
      e.err   = (addr[1:0] != 2'b00);
    end else if (addr[1:0] != 2'b00) begin
      e.err = 1'b1;
    end else if (delay > TO) begin
      e.err = 1'b1;
    end else begin
      e.err = 1'b0;
      ref_mem[wi] = merge(ref_mem[wi], wdata, wsize);
    end
    if (track) push_exp(p, e);
    pend_delay[addr[7:6]] = delay;
    req_addr[p*W +: W]  = addr;
    req_wdata[p*W +: W] = wdata;
    req_wsize[p*2 +: 2] = wsize;
    req[p]              = 1'b1;
  endtask

  task automatic drop(input int p);
    req[p] = 1'b0;
  endtask

  task automatic run_one(input int p, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] wsize, input int delay, input int exp_lat);
    int lat;
    issue(p, addr, wdata, wsize, delay, 1'b1);
    lat = 0;
    while (!ack[p] && lat < 60) begin
      tick();
      lat++;
    end
    chk("run_ack_seen", {31'd0, ack[p]}, 32'd1);
    chk("run_latency", 32'(lat), 32'(exp_lat));
    drop(p);
    tick();
  endtask

  function automatic logic [31:0] rand_addr(input int p);
    logic [1:0] lo;
    lo = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    return {24'd0, 2'(p), 4'($urandom_range(0, 15)), lo};
  endfunction

  initial begin
    int  issued [3];
    bit  busy   [3];
    int  cyc;
    int  dly;
    logic [1:0] ws;

    rst = 1'b1; tb_init = 1'b1;
    req = '0; req_addr = '0; req_wdata = '0; req_wsize = '0;
    for (int i = 0; i < 4; i++) pend_delay[i] = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    repeat (3) tick();
    tb_init = 1'b0;

    // Reset state
    chk("rst_ack", {29'd0, ack}, 32'd0);
    chk("rst_mem_write", {30'd0, mem_write}, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;
    tick();

    // Read, port 2 only (its nonzero size must be ignored)
    issue(2, 32'h10, 32'h0, 2'b11, 0, 1'b1);
    tick(); chk("t1_addr_c1", mem_address, 32'h10); chk("t1_nowrite", {30'd0, mem_write}, 32'd0);
    tick(); chk("t1_addr_c2", mem_address, 32'h10);
    tick(); chk("t1_ack", {29'd0, ack}, 32'b100); chk("t1_rdata", rsp_rdata, 32'h00500093);
    drop(2);
    tick();

    // Contention between ports 1 and 2
    issue(1, 32'h44, 32'h0, 2'b00, 0, 1'b1);
    issue(2, 32'h88, 32'h0, 2'b01, 0, 1'b1);
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c <= 2) chk("t2_p1_addr", mem_address, 32'h44);
      if (c == 3) begin chk("t2_ack_p1", {29'd0, ack}, 32'b010); drop(1); end
      if (c == 4) chk("t2_gap", {29'd0, ack}, 32'd0);
      if (c == 5 || c == 6) chk("t2_p2_addr", mem_address, 32'h88);
      if (c == 7) begin chk("t2_ack_p2", {29'd0, ack}, 32'b100); drop(2); end
    end
    tick();

    // Word write, port 1, done 3 cycles after WR_DRV entry
    issue(1, 32'h20, 32'hDEADBEEF, 2'b10, 3, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) chk("t3_wrchk", {30'd0, mem_write}, 32'd0);
      if (c >= 2 && c <= 5) chk("t3_mem_write", {30'd0, mem_write}, 32'b10);
      if (c == 2) chk("t3_wdata", mem_wdata, 32'hDEADBEEF);
      if (c == 6) begin
        chk("t3_ack", {29'd0, ack}, 32'b010);
        chk("t3_err", {31'd0, rsp_err}, 32'd0);
        chk("t3_write_off", {30'd0, mem_write}, 32'd0);
        drop(1);
      end
    end
    tick();
    run_one(1, 32'h20, 32'h0, 2'b00, 0, 3);
    chk("t3_readback", rsp_rdata, 32'hDEADBEEF);

    // Misaligned write
    issue(1, 32'h21, 32'h12345678, 2'b10, 0, 1'b1);
    tick(); chk("t4_nowrite_c1", {30'd0, mem_write}, 32'd0);
    tick(); chk("t4_ack", {29'd0, ack}, 32'b010); chk("t4_err", {31'd0, rsp_err}, 32'd1);
    chk("t4_nowrite_c2", {30'd0, mem_write}, 32'd0);
    drop(1);
    tick();
    run_one(0, 32'h20, 32'h0, 2'b00, 0, 3);
    chk("t4_mem_untouched", rsp_rdata, 32'hDEADBEEF);

    // Timeout
    issue(0, 32'h30, 32'hCAFEF00D, 2'b10, 255, 1'b1);
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) chk("t5_wrchk", {30'd0, mem_write}, 32'd0);
      if (c >= 2 && c <= 6) chk("t5_mem_write", {30'd0, mem_write}, 32'b10);
      if (c == 7) begin
        chk("t5_ack", {29'd0, ack}, 32'b001);
        chk("t5_err", {31'd0, rsp_err}, 32'd1);
        chk("t5_write_off", {30'd0, mem_write}, 32'd0);
        drop(0);
      end
    end
    tick();
    run_one(2, 32'h10, 32'h0, 2'b00, 0, 3);
    chk("t5_next_read", rsp_rdata, 32'h00500093);

    // Reset during WR_DRV: no ack for the aborted write
    issue(0, 32'h34, 32'h11112222, 2'b10, 255, 1'b0);
    tick();
    tick(); chk("t6_in_wrdrv", {30'd0, mem_write}, 32'b10);
    tick();
    rst = 1'b1; drop(0);
    tick();
    chk("t6_ack", {29'd0, ack}, 32'd0);
    chk("t6_mem_write", {30'd0, mem_write}, 32'd0);
    chk("t6_mem_address", mem_address, 32'd0);
    chk("t6_mem_wdata", mem_wdata, 32'd0);
    chk("t6_rsp_rdata", rsp_rdata, 32'd0);
    chk("t6_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("t6_no_ack", {29'd0, ack}, 32'd0);
    end
    run_one(0, 32'h08, 32'h0, 2'b00, 0, 3);

    // Randomized three-port traffic
    for (int p = 0; p < 3; p++) begin issued[p] = 0; busy[p] = 1'b0; end
    cyc = 0;
    while (cyc < 20000 &&
           (busy[0] || busy[1] || busy[2] ||
            issued[0] < N_PER_PORT || issued[1] < N_PER_PORT || issued[2] < N_PER_PORT)) begin
      tick();
      cyc++;
      for (int p = 0; p < 3; p++) begin
        if (busy[p] && ack[p]) begin
          busy[p] = 1'b0;
          if (issued[p] >= N_PER_PORT || $urandom_range(0, 1) == 0) drop(p);
        end
        if (!busy[p] && issued[p] < N_PER_PORT && (req[p] || $urandom_range(0, 3) == 0)) begin
          if (p == 2) ws = 2'($urandom_range(0, 3));
          else ws = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
          dly = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 5);
          issue(p, rand_addr(p), $urandom, ws, dly, 1'b1);
          busy[p] = 1'b1;
          issued[p]++;
        end
      end
    end
    chk("rand_complete", {31'd0, (busy[0] || busy[1] || busy[2])}, 32'd0);
    repeat (6) tick();
    chk("sb_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
